// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built when MD_MADD_EN is defined.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [0:0]       state_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
  localparam logic [1:0] K_ADD    = 2'd2;
  localparam logic [1:0] K_SUB    = 2'd3;
`endif
  localparam logic [1:0] K_WRITE  = 2'd0;
  localparam logic [1:0] K_SKIP   = 2'd1;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [1:0]         kind_q, kind_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
  logic [WIDTH-1:0]   sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Signed divide is done on magnitudes so most-negative / -1 needs no special case.
  assign a_neg      = a_i[WIDTH-1];
  assign b_neg      = b_i[WIDTH-1];
  assign b_zero     = (b_i == '0);
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = b_neg ? -b_i : b_i;
  assign b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_i;
  assign sq_mag     = a_mag / b_mag_safe;
  assign sr_mag     = a_mag % b_mag_safe;
  assign s_quo      = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
  assign s_rem      = a_neg ? -sr_mag : sr_mag;
  assign u_quo      = a_i / b_safe;
  assign u_rem      = a_i % b_safe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    kind_d  = kind_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          case (op_i)
            OP_MULT:  begin res_d = prod_s; kind_d = K_WRITE; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
            OP_MULTU: begin res_d = prod_u; kind_d = K_WRITE; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
            OP_DIV: begin
              res_d   = {s_rem, s_quo};
              kind_d  = b_zero ? K_SKIP : K_WRITE;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_DIVU: begin
              res_d   = {u_rem, u_quo};
              kind_d  = b_zero ? K_SKIP : K_WRITE;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
`ifdef MD_MADD_EN
            OP_MADD:  begin res_d = prod_s; kind_d = K_ADD; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
            OP_MADDU: begin res_d = prod_u; kind_d = K_ADD; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
            OP_MSUB:  begin res_d = prod_s; kind_d = K_SUB; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
            OP_MSUBU: begin res_d = prod_u; kind_d = K_SUB; cnt_d = CW'(MULT_CYCLES); state_d = S_RUN; end
`endif
            default: ;
          endcase
        end
      end
      default: begin
        // Abort beats the final-count commit; accumulate ops read {hi,lo} at commit.
        if (abort_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          case (kind_q)
            K_WRITE: {hi_d, lo_d} = res_q;
`ifdef MD_MADD_EN
            K_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + res_q;
            K_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - res_q;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      kind_q  <= K_WRITE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      kind_q  <= kind_d;
    end
  end

  // busy_o is the stall request: while high, start_i is ignored for every op.
  assign busy_o  = (state_q == S_RUN);
  assign state_o = state_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign rdata_o = (op_i == OP_MFHI) ? hi_q : (op_i == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written abort/reset/busy sequences,
// and randomized ops scored against an arithmetic model of HI/LO.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset_n, start, abort;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] hi, lo, rdata;
  logic [0:0]   state;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .abort_i(abort), .busy_o(busy), .hi_o(hi), .lo_o(lo), .rdata_o(rdata), .state_o(state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [31:0] a, b, hi, lo;
    int         cyc;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) check({name, ":timeout"}, 64'(busy), 64'd0);
  endtask

  // Issue one op, measure busy length, then compare HI/LO and the mfhi/mflo read path.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int ecyc);
    logic [W-1:0] pre_hi, pre_lo;
    int  cyc;
    bit  stable;
    pre_hi = hi;
    pre_lo = lo;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 4'd0;
    cyc = 0;
    stable = 1'b1;
    while (busy === 1'b1 && cyc < 64) begin
      if (hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      tick();
      cyc++;
    end
    check({name, ":busy_cycles"}, 64'(cyc), 64'(ecyc));
    if (ecyc > 0) check({name, ":hold_while_busy"}, 64'(stable), 64'd1);
    check({name, ":hi"}, 64'(hi), 64'(exp_q.pop_front()));
    check({name, ":lo"}, 64'(lo), 64'(exp_q.pop_front()));
    op = 4'd5; #1;
    check({name, ":mfhi"}, 64'(rdata), 64'(eh));
    op = 4'd6; #1;
    check({name, ":mflo"}, 64'(rdata), 64'(el));
    op = 4'd0; #1;
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl, output int cyc);
    int sx, sy;
    longint p;
    logic [63:0] acc, pu;
    sx = x; sy = y;
    nh = h; nl = l; cyc = 0;
    acc = {h, l};
    p  = longint'(sx) * longint'(sy);
    pu = {32'b0, x} * {32'b0, y};
    case (o)
      4'd1: begin {nh, nl} = p;  cyc = MC; end
      4'd2: begin {nh, nl} = pu; cyc = MC; end
      4'd3: nh = x;
      4'd4: nl = x;
      4'd7: begin
        cyc = DC;
        if (y != 0) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin nl = x; nh = 0; end
          else begin nl = sx / sy; nh = sx % sy; end
        end
      end
      4'd8: begin
        cyc = DC;
        if (y != 0) begin nl = x / y; nh = x % y; end
      end
`ifdef MD_MADD_EN
      4'd9:  begin {nh, nl} = acc + p;  cyc = MC; end
      4'd10: begin {nh, nl} = acc + pu; cyc = MC; end
      4'd11: begin {nh, nl} = acc - p;  cyc = MC; end
      4'd12: begin {nh, nl} = acc - pu; cyc = MC; end
`endif
      default: ;
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [3:0]  ro;
    int ec;

    vecs[0]  = '{"mult_neg",   4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1]  = '{"multu",      4'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, MC};
    vecs[2]  = '{"div_neg",    4'd7, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[3]  = '{"div_ovf",    4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, DC};
    vecs[4]  = '{"divu_zero",  4'd8, 32'd7,         32'd0,        32'h0,         32'h8000_0000, DC};
    vecs[5]  = '{"mthi",       4'd3, 32'h1234,      32'd0,        32'h1234,      32'h8000_0000, 0};
    vecs[6]  = '{"mtlo",       4'd4, 32'h55,        32'd0,        32'h1234,      32'h55,        0};
    vecs[7]  = '{"op0",        4'd0, 32'hAAAA,      32'hBBBB,     32'h1234,      32'h55,        0};
    vecs[8]  = '{"op13",       4'd13, 32'hAAAA,     32'hBBBB,     32'h1234,      32'h55,        0};
    vecs[9]  = '{"divu",       4'd8, 32'd100,       32'd7,        32'd2,         32'd14,        DC};
    vecs[10] = '{"mult_max",   4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MC};
    vecs[11] = '{"div_negb",   4'd7, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DC};
    vecs[12] = '{"div_zero",   4'd7, 32'd9,         32'd0,        32'd1,         32'hFFFF_FFFD, DC};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 4'd0; a = '0; b = '0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:hi", 64'(hi), 64'd0);
    check("reset:lo", 64'(lo), 64'd0);
    check("reset:state", 64'(state), 64'd0);
    op = 4'd5; #1; check("reset:mfhi", 64'(rdata), 64'd0);
    op = 4'd6; #1; check("reset:mflo", 64'(rdata), 64'd0);
    op = 4'd0; #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);

    // mtlo/mthi issued while busy must be ignored.
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    tick();
    op = 4'd4; a = 32'h99;
    tick();
    op = 4'd3; a = 32'h77;
    tick();
    start = 1'b0; op = 4'd0;
    wait_idle("mt_busy");
    check("mt_busy:hi", 64'(hi), 64'd0);
    check("mt_busy:lo", 64'(lo), 64'hC);

    run_op("set_hi", 4'd3, 32'h1111, 32'd0, 32'h1111, 32'hC, 0);
    run_op("set_lo", 4'd4, 32'h2222, 32'd0, 32'h1111, 32'h2222, 0);

    // Abort during the 3rd busy cycle.
    start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0; op = 4'd0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort3:busy", 64'(busy), 64'd0);
    tick(); tick(); tick(); tick();
    check("abort3:hi", 64'(hi), 64'h1111);
    check("abort3:lo", 64'(lo), 64'h2222);

    // Abort on the final busy cycle: commit edge, abort wins.
    start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0; op = 4'd0;
    tick(); tick(); tick(); tick();
    check("abort5:still_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort5:busy", 64'(busy), 64'd0);
    check("abort5:hi", 64'(hi), 64'h1111);
    check("abort5:lo", 64'(lo), 64'h2222);

    // Abort in IDLE suppresses a same-cycle start.
    start = 1'b1; abort = 1'b1; op = 4'd3; a = 32'hDEAD;
    tick();
    check("abort_idle:mthi", 64'(hi), 64'h1111);
    op = 4'd1; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0; abort = 1'b0; op = 4'd0;
    check("abort_idle:busy", 64'(busy), 64'd0);

    run_op("mult_after_abort", 4'd1, 32'd5, 32'd7, 32'd0, 32'd35, MC);

    // Reset in the middle of a divide.
    start = 1'b1; op = 4'd7; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0; op = 4'd0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("reset_mid:busy", 64'(busy), 64'd0);
    check("reset_mid:hi", 64'(hi), 64'd0);
    check("reset_mid:lo", 64'(lo), 64'd0);
    tick(); tick();
    check("reset_mid:busy_later", 64'(busy), 64'd0);
    m_hi = 0; m_lo = 0;

`ifdef MD_MADD_EN
    run_op("madd_pre_lo", 4'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("madd", 4'd9, 32'd1, 32'd1, 32'd1, 32'd0, MC);
    run_op("msubu", 4'd12, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, MC);
`else
    run_op("madd_pre_lo", 4'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("op9_noop", 4'd9, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      model(ro, ra, rb, m_hi, m_lo, eh, el, ec);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, eh, el, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
